// File: rtl/priority_encoder_32to5.sv
// Sticky 32-line request collector that drains lowest-index-first into a valid/ready slot; 2-cycle req-to-out latency.
// Backpressure: slot and pending clears freeze while out_valid & ~out_ready; new requests keep merging into pending.
module priority_encoder_32to5 #(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             any_pending
);

  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     sel;
  logic [N-1:0]     clr;
  logic [IDX_W-1:0] sel_idx;
  logic             slot_free;
  logic             load;

  assign sel       = pending_q & ~mask;
  assign slot_free = ~out_valid_q | out_ready;
  assign load      = slot_free & (|sel);

  // Scan high-to-low so the last hit left standing is the lowest set index.
  always_comb begin
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  // Set is OR-ed in after the clear, so a same-cycle request on the loaded bit survives.
  always_comb begin
    clr         = '0;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    if (load) begin
      clr         = N'(1) << sel_idx;
      out_idx_d   = sel_idx;
      out_valid_d = 1'b1;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
    pending_d = (pending_q & ~clr) | (req & {N{enable}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_idx     = out_idx_q;
  assign out_valid   = out_valid_q;
  assign pending     = pending_q;
  assign any_pending = |sel;

endmodule

// File: tb/tb_priority_encoder_32to5.sv
// Directed bench for priority_encoder_32to5: hand-computed vectors checked with immediate assertions.
module tb_priority_encoder_32to5;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] req;
  logic [31:0] mask;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pending;
  logic        any_pending;

  int checks = 0;
  int passed = 0;

  priority_encoder_32to5 dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .mask        (mask),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pending     (pending),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_slot(input string tag, input logic vld, input logic [4:0] idx, input logic [31:0] pend);
    check({tag, "_valid"}, 32'(out_valid), 32'(vld));
    if (vld) check({tag, "_idx"}, 32'(out_idx), 32'(idx));
    check({tag, "_pending"}, pending, pend);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; req = 32'hFFFF_FFFF; mask = '0; out_ready = 1'b0;

    // Reset for two edges with requests asserted
    step(); step();
    check("rst_pending", pending, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_idx", 32'(out_idx), 32'h0);
    check("rst_any", 32'(any_pending), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_pending", pending, 32'hFFFF_FFFF);
    check("post_rst_any", 32'(any_pending), 32'h1);
    check("post_rst_valid", 32'(out_valid), 32'h0);
    req = '0;
    step();
    check_slot("first_load", 1'b1, 5'd0, 32'hFFFF_FFFE);
    // Mid-operation reset discards everything
    rst = 1'b1; req = 32'h0000_0F00;
    step();
    check_slot("midrst", 1'b0, 5'd0, 32'h0);
    check("midrst_idx", 32'(out_idx), 32'h0);
    rst = 1'b0; req = '0;
    step();
    check_slot("midrst_idle", 1'b0, 5'd0, 32'h0);

    // Ordered drain
    out_ready = 1'b1; req = 32'h8001_0024;
    step();
    check_slot("drain_cap", 1'b0, 5'd0, 32'h8001_0024);
    req = '0;
    step(); check_slot("drain_2", 1'b1, 5'd2, 32'h8001_0020);
    step(); check_slot("drain_5", 1'b1, 5'd5, 32'h8001_0000);
    step(); check_slot("drain_16", 1'b1, 5'd16, 32'h8000_0000);
    step(); check_slot("drain_31", 1'b1, 5'd31, 32'h0);
    step(); check_slot("drain_empty", 1'b0, 5'd0, 32'h0);
    check("drain_idx_hold", 32'(out_idx), 32'd31);

    // Backpressure
    out_ready = 1'b0; req = 32'h0000_0009;
    step(); check_slot("bp_cap", 1'b0, 5'd0, 32'h9);
    req = '0;
    step(); check_slot("bp_load", 1'b1, 5'd0, 32'h8);
    for (int i = 0; i < 10; i++) begin
      step(); check_slot("bp_hold", 1'b1, 5'd0, 32'h8);
    end
    out_ready = 1'b1;
    step(); check_slot("bp_3", 1'b1, 5'd3, 32'h0);
    step(); check_slot("bp_empty", 1'b0, 5'd0, 32'h0);

    // Masking
    mask = 32'h1; req = 32'h3;
    step(); check_slot("mask_cap", 1'b0, 5'd0, 32'h3);
    check("mask_any_cap", 32'(any_pending), 32'h1);
    req = '0;
    step(); check_slot("mask_1", 1'b1, 5'd1, 32'h1);
    check("mask_any_1", 32'(any_pending), 32'h0);
    step(); check_slot("mask_idle", 1'b0, 5'd0, 32'h1);
    step(); check_slot("mask_idle2", 1'b0, 5'd0, 32'h1);
    check("mask_any_idle", 32'(any_pending), 32'h0);
    mask = '0;
    #1;
    check("unmask_any", 32'(any_pending), 32'h1);
    step(); check_slot("unmask_0", 1'b1, 5'd0, 32'h0);
    step(); check_slot("unmask_empty", 1'b0, 5'd0, 32'h0);

    // Set-wins collision on index 4
    req = 32'h10;
    step(); check_slot("coll_cap", 1'b0, 5'd0, 32'h10);
    step(); check_slot("coll_first", 1'b1, 5'd4, 32'h10);
    req = '0;
    step(); check_slot("coll_second", 1'b1, 5'd4, 32'h0);
    step(); check_slot("coll_empty", 1'b0, 5'd0, 32'h0);

    // Enable gating
    out_ready = 1'b0; req = 32'h5;
    step(); check_slot("en_cap", 1'b0, 5'd0, 32'h5);
    req = '0;
    step(); check_slot("en_load", 1'b1, 5'd0, 32'h4);
    enable = 1'b0; req = 32'hFFFF_FFFF;
    step(); check_slot("en_gated_hold", 1'b1, 5'd0, 32'h4);
    out_ready = 1'b1;
    step(); check_slot("en_gated_2", 1'b1, 5'd2, 32'h0);
    step(); check_slot("en_gated_empty", 1'b0, 5'd0, 32'h0);
    enable = 1'b1; req = '0;
    step(); check_slot("final_idle", 1'b0, 5'd0, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder_32to5.md
# priority_encoder_32to5

Registered 32-to-5 priority encoder with a sticky pending register and a valid/ready output slot. It is the encoding counterpart of the team's one-hot decoders. It collects single-cycle or level request strobes on 32 lines and drains them one at a time, lowest index first, as 5-bit binary indices to a downstream consumer. Typical use is interrupt/event funnelling ahead of a 5-to-32 decode stage.

## Interface
- `N`, default 32: number of request lines; fixed at 32 for this block.
- `IDX_W`, default 5: index width; must equal log2(N).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: when high, `req` is captured into pending; when low, capture is suppressed.
- `req` input 32: request strobes; bit i high for one or more cycles marks event i.
- `mask` input 32: bit i high excludes pending bit i from selection. Masking does not clear or block capture.
- `out_idx` output 5: encoded index of the event being presented.
- `out_valid` output 1: `out_idx` holds a valid event.
- `out_ready` input 1: consumer accepts when `out_valid & out_ready`.
- `pending` output 32: current pending register, unmasked.
- `any_pending` output 1: OR of (`pending` & ~`mask`), combinational from registers.

## Operation
- Pending register P, one sticky bit per line.
  - Each cycle: P_next = (P & ~clr) | (req & {32{enable}}).
  - clr is one-hot at the selected index in a load cycle, and zero otherwise.
- Output slot.
  - The slot is free when `out_valid`=0, or when `out_valid & out_ready` (a pop).
  - In a free cycle with S = P & ~mask nonzero, the slot loads: `out_idx` = lowest set index of S, `out_valid`=1, and bit `out_idx` of P is cleared.
  - In a free cycle with S = 0: on a pop, `out_valid` goes to 0; `out_idx` holds its last value.
- Stalling: while `out_valid & ~out_ready`, `out_idx` and `out_valid` are frozen and no P bit is cleared.
- Simultaneous set and clear of the same bit: set wins. The bit stays pending, and the event is re-presented later as a distinct occurrence.
- A request on a bit already pending merges (no counting).
- Priority is strictly fixed: index 0 highest, 31 lowest. No fairness or rotation.
- Mask changes take effect on the next selection. An index already in the slot is not revoked by masking it.
- Reset values: P=0, `out_valid`=0, `out_idx`=0, `pending`=0, `any_pending`=0.
- Reset asserted mid-operation discards all pending and in-slot events. `req` in the reset cycle is ignored.

## Timing
- Latency: `req[i]` high at edge k sets P[i] after edge k. With the slot free at edge k+1 and i the lowest unmasked bit, `out_valid`=1 / `out_idx`=i after edge k+1. Minimum latency is 2 cycles from request to presentation.
- Throughput: one index per cycle while `out_ready` is held high and S stays nonzero (back-to-back pops and loads).
- The handshake follows standard valid/ready rules:
  - `out_valid` never drops without a pop.
  - `out_valid` does not depend combinationally on `out_ready`.
  - `out_ready` may be high while `out_valid`=0, with no effect.
- `pending` reflects P after the edge, including the clear of the index just loaded.

## Test plan
- Reset then idle: drive `rst`=1 for 2 cycles with `req`=0xFFFFFFFF and `enable`=1. Require `pending`=0 and `out_valid`=0 in the cycle after `rst` falls. Require `pending`=0xFFFFFFFF one cycle later.
- Ordered drain: pulse `req`=0x80010024 for one cycle with `out_ready`=1 and `mask`=0. Require `out_idx` sequence 2, 5, 16, 31 on 4 consecutive cycles, then `out_valid`=0 and `pending`=0.
- Backpressure: `req`=0x00000009 with `out_ready`=0. Require `out_idx`=0 held stable for 10 cycles and `pending`=0x8. Raise `out_ready`; require 3 presented next, then empty.
- Masking: `req`=0x00000003 with `mask`=0x1. Require only index 1 to be presented and `pending`=0x1 to remain with `any_pending`=0. Clear the mask; require index 0 within 1 cycle.
- Set-wins collision: with index 4 being loaded, assert `req[4]` in the same cycle. Require index 4 to be presented twice in total.
- Enable gating: `enable`=0 with `req`=0xFFFFFFFF. Require `pending` unchanged and draining to continue normally.
